// File: rtl/puf_uart_ctrl_if.sv
// puf_uart_ctrl_if: UART byte, PUF and memory-record signals for puf_uart_ctrl.
// master = environment side (UART RX/TX, PUF core), slave = the controller.
interface puf_uart_ctrl_if #(
  parameter int unsigned CHAL_BYTES = 1,
  parameter int unsigned RESP_BYTES = 32,
  parameter int unsigned MEM_BYTES  = 33
);
  logic [7:0]              rx_byte;
  logic                    rx_DV;
  logic [8*RESP_BYTES-1:0] response;
  logic                    response_DV;
  logic                    uart_done;
  logic                    mem_we;
  logic [8*CHAL_BYTES-1:0] challenge;
  logic                    start;
  logic [7:0]              tx_byte;
  logic                    tx_DV;
  logic                    done;
  logic                    err;
  logic                    busy;
  logic                    led;
  logic [8*MEM_BYTES-1:0]  mem_data;
  logic                    mem_DV;

  modport master (
    output rx_byte, rx_DV, response, response_DV, uart_done, mem_we,
    input  challenge, start, tx_byte, tx_DV, done, err, busy, led, mem_data, mem_DV
  );

  modport slave (
    input  rx_byte, rx_DV, response, response_DV, uart_done, mem_we,
    output challenge, start, tx_byte, tx_DV, done, err, busy, led, mem_data, mem_DV
  );
endinterface

// File: rtl/puf_uart_ctrl.sv
// puf_uart_ctrl: assembles UART challenges, returns challenge+response bytes, or captures memory-write records.
// Build option: define PUF_UART_CRC8_EN to append a CRC-8 (poly 0x07, init 0) byte after the response.
module puf_uart_ctrl #(
  parameter int unsigned CHAL_BYTES = 1,
  parameter int unsigned RESP_BYTES = 32,
  parameter int unsigned MEM_BYTES  = 33,
  parameter int unsigned TIMEOUT    = 65535
) (
  input logic            clk,
  input logic            reset,
  puf_uart_ctrl_if.slave bus
);
  localparam int unsigned CW    = 8 * CHAL_BYTES;
  localparam int unsigned MW    = 8 * MEM_BYTES;
  localparam int unsigned TB    = CHAL_BYTES + RESP_BYTES;
  localparam int unsigned TW    = 8 * TB;
  localparam int unsigned RXMAX = (CHAL_BYTES > MEM_BYTES) ? CHAL_BYTES : MEM_BYTES;
  localparam int unsigned RXCW  = $clog2(RXMAX + 1);
  localparam int unsigned TXCW  = $clog2(TB + 1);
  localparam int unsigned TOW   = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    SLEEP, RECVC, WAITRESP, SEND, WAITTX, SENDCRC, WAITCRC, END, RECV_MEM
  } state_t;

  state_t          r_state, w_state;
  logic [RXCW-1:0] r_rx_cnt, w_rx_cnt, w_rx_cnt_inc;
  logic [TXCW-1:0] r_tx_cnt, w_tx_cnt;
  logic [TOW-1:0]  r_tmo, w_tmo;
  logic [CW-1:0]   r_chal_buf, w_chal_buf, w_chal_sh;
  logic [MW-1:0]   r_mem_buf, w_mem_buf, w_mem_sh;
  logic [TW-1:0]   r_txbuf, w_txbuf;
  logic [CW-1:0]   r_challenge, w_challenge;
  logic [7:0]      r_tx_byte, w_tx_byte;
  logic [MW-1:0]   r_mem_data, w_mem_data;
  logic            r_start, w_start, r_tx_dv, w_tx_dv, r_done, w_done, r_err, w_err;
  logic            r_busy, w_busy, r_led, w_led, r_mem_dv, w_mem_dv;
  logic            w_take_chal, w_take_mem;
`ifdef PUF_UART_CRC8_EN
  logic [7:0]      r_crc, w_crc;

  // One byte of MSB-first CRC-8, polynomial x^8+x^2+x+1.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction
`endif

  // The first byte of a transaction is sampled in SLEEP; mem_we only matters there.
  assign w_take_chal  = bus.rx_DV && ((r_state == SLEEP && !bus.mem_we) || r_state == RECVC);
  assign w_take_mem   = bus.rx_DV && ((r_state == SLEEP && bus.mem_we) || r_state == RECV_MEM);
  assign w_rx_cnt_inc = r_rx_cnt + RXCW'(1);
  assign w_chal_sh    = ((r_state == SLEEP) ? CW'(0) : (r_chal_buf << 8)) | CW'(bus.rx_byte);
  assign w_mem_sh     = ((r_state == SLEEP) ? MW'(0) : (r_mem_buf << 8)) | MW'(bus.rx_byte);

  always_comb begin
    w_state     = r_state;
    w_rx_cnt    = r_rx_cnt;
    w_tx_cnt    = r_tx_cnt;
    w_tmo       = r_tmo;
    w_chal_buf  = r_chal_buf;
    w_mem_buf   = r_mem_buf;
    w_txbuf     = r_txbuf;
    w_challenge = r_challenge;
    w_tx_byte   = r_tx_byte;
    w_mem_data  = r_mem_data;
    w_start     = 1'b0;
    w_tx_dv     = 1'b0;
    w_done      = 1'b0;
    w_err       = 1'b0;
    w_mem_dv    = 1'b0;
`ifdef PUF_UART_CRC8_EN
    w_crc       = r_crc;
`endif
    case (r_state)
      SLEEP, RECVC, RECV_MEM: begin
        if (w_take_chal) begin
          w_chal_buf = w_chal_sh;
          w_rx_cnt   = w_rx_cnt_inc;
          w_state    = RECVC;
          if (w_rx_cnt_inc == RXCW'(CHAL_BYTES)) begin
            w_challenge = w_chal_sh;
            w_start     = 1'b1;
            w_state     = WAITRESP;
          end
        end else if (w_take_mem) begin
          w_mem_buf = w_mem_sh;
          w_rx_cnt  = w_rx_cnt_inc;
          w_state   = RECV_MEM;
          if (w_rx_cnt_inc == RXCW'(MEM_BYTES)) begin
            w_mem_data = w_mem_sh;
            w_mem_dv   = 1'b1;
            w_done     = 1'b1;
            w_state    = SLEEP;
          end
        end
      end
      WAITRESP: begin
        if (bus.response_DV) begin
          w_txbuf = {r_challenge, bus.response};
          w_state = SEND;
        end else if (r_tmo == TOW'(TIMEOUT - 1)) begin
          w_err   = 1'b1;
          w_state = SLEEP;
        end else begin
          w_tmo = r_tmo + TOW'(1);
        end
      end
      SEND: begin
        w_tx_byte = r_txbuf[TW-1 -: 8];
        w_tx_dv   = 1'b1;
        w_txbuf   = r_txbuf << 8;
        w_tx_cnt  = r_tx_cnt + TXCW'(1);
`ifdef PUF_UART_CRC8_EN
        w_crc     = crc8_step(r_crc, r_txbuf[TW-1 -: 8]);
`endif
        w_state   = WAITTX;
      end
      // A uart_done coinciding with our own tx_DV belongs to an earlier byte.
      WAITTX: begin
        if (bus.uart_done && !r_tx_dv) begin
`ifdef PUF_UART_CRC8_EN
          w_state = (r_tx_cnt == TXCW'(TB)) ? SENDCRC : SEND;
`else
          w_state = (r_tx_cnt == TXCW'(TB)) ? END : SEND;
`endif
        end
      end
`ifdef PUF_UART_CRC8_EN
      SENDCRC: begin
        w_tx_byte = r_crc;
        w_tx_dv   = 1'b1;
        w_state   = WAITCRC;
      end
      WAITCRC: begin
        if (bus.uart_done && !r_tx_dv) w_state = END;
      end
`endif
      END: begin
        w_done  = 1'b1;
        w_state = SLEEP;
      end
      default: w_state = SLEEP;
    endcase

    if (w_state == SLEEP) begin
      w_rx_cnt = '0;
      w_tx_cnt = '0;
      w_tmo    = '0;
`ifdef PUF_UART_CRC8_EN
      w_crc    = '0;
`endif
    end
    w_busy = (w_state != SLEEP);
    w_led  = (w_state == RECV_MEM);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= SLEEP;
      r_rx_cnt    <= '0;
      r_tx_cnt    <= '0;
      r_tmo       <= '0;
      r_chal_buf  <= '0;
      r_mem_buf   <= '0;
      r_txbuf     <= '0;
      r_challenge <= '0;
      r_tx_byte   <= '0;
      r_mem_data  <= '0;
      r_start     <= 1'b0;
      r_tx_dv     <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_led       <= 1'b0;
      r_mem_dv    <= 1'b0;
`ifdef PUF_UART_CRC8_EN
      r_crc       <= '0;
`endif
    end else begin
      r_state     <= w_state;
      r_rx_cnt    <= w_rx_cnt;
      r_tx_cnt    <= w_tx_cnt;
      r_tmo       <= w_tmo;
      r_chal_buf  <= w_chal_buf;
      r_mem_buf   <= w_mem_buf;
      r_txbuf     <= w_txbuf;
      r_challenge <= w_challenge;
      r_tx_byte   <= w_tx_byte;
      r_mem_data  <= w_mem_data;
      r_start     <= w_start;
      r_tx_dv     <= w_tx_dv;
      r_done      <= w_done;
      r_err       <= w_err;
      r_busy      <= w_busy;
      r_led       <= w_led;
      r_mem_dv    <= w_mem_dv;
`ifdef PUF_UART_CRC8_EN
      r_crc       <= w_crc;
`endif
    end
  end

  assign bus.challenge = r_challenge;
  assign bus.start     = r_start;
  assign bus.tx_byte   = r_tx_byte;
  assign bus.tx_DV     = r_tx_dv;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.busy      = r_busy;
  assign bus.led       = r_led;
  assign bus.mem_data  = r_mem_data;
  assign bus.mem_DV    = r_mem_dv;
endmodule

// File: doc/puf_uart_ctrl.md
PUF_UART_CTRL -- requirements
Module: puf_uart_ctrl

Interface
REQ-001 SHALL expose parameter CHAL_BYTES, default 1, number of challenge bytes per transaction (1..16).
REQ-002 SHALL expose parameter RESP_BYTES, default 32, number of response bytes returned (1..64).
REQ-003 SHALL expose parameter MEM_BYTES, default 33, number of bytes per memory-write record (1..64).
REQ-004 SHALL expose parameter TIMEOUT, default 65535, number of cycles to wait for response_DV before aborting (>=1).
REQ-005 SHALL have one clock and one reset: `clk` is the single clock, and `reset` is asynchronous and active-low.
REQ-006 Ports SHALL be:
- `clk`  in  1  system clock
- `reset`  in  1  async active-low reset
- `rx_byte`  in  8  received UART byte
- `rx_DV`  in  1  rx_byte valid, one-cycle pulse
- `response`  in  8*RESP_BYTES  PUF response
- `response_DV`  in  1  response valid pulse
- `uart_done`  in  1  transmitter finished current byte, pulse
- `mem_we`  in  1  memory-write mode select
- `challenge`  out  8*CHAL_BYTES  assembled challenge
- `start`  out  1  PUF start pulse
- `tx_byte`  out  8  byte to transmit
- `tx_DV`  out  1  tx_byte valid pulse
- `done`  out  1  transaction complete pulse
- `err`  out  1  timeout pulse
- `busy`  out  1  high whenever state != SLEEP
- `led`  out  1  high while in RECV_MEM
- `mem_data`  out  8*MEM_BYTES  record
- `mem_DV`  out  1  mem_data valid pulse

Function
REQ-007 States SHALL be: SLEEP, RECVC, WAITRESP, SEND, WAITTX, SENDCRC, WAITCRC, END, RECV_MEM.
REQ-008 In SLEEP, the first rx_DV SHALL sample mem_we:
- mem_we=1: store the byte as record byte 0 and go to RECV_MEM.
- mem_we=0: store the byte as challenge byte 0 and go to RECVC.
REQ-009 Bytes SHALL be assembled MSB-first: the first received byte occupies the top byte of challenge or mem_data.
REQ-010 Challenge update:
- RECVC SHALL accept further rx_DV bytes until CHAL_BYTES have been received.
- challenge SHALL update atomically, one cycle after the last byte.
- start SHALL pulse for exactly 1 cycle in that same cycle, then the FSM enters WAITRESP.
- For CHAL_BYTES=1, the FSM goes from SLEEP directly to WAITRESP with the same timing.
REQ-011 WAITRESP SHALL latch response on response_DV and go to SEND; after TIMEOUT cycles without response_DV it SHALL pulse err for 1 cycle and return to SLEEP.
REQ-012 Transmit sequence: SEND SHALL drive tx_byte and pulse tx_DV for 1 cycle, sending CHAL_BYTES challenge bytes then RESP_BYTES response bytes, each MSB-first.
REQ-013 WAITTX SHALL hold until uart_done, then:
- return to SEND if bytes remain;
- otherwise go to SENDCRC (macro defined) or END.
REQ-014 END SHALL pulse done for 1 cycle and return to SLEEP.
REQ-015 RECV_MEM SHALL accept bytes until MEM_BYTES total, then load mem_data, pulse mem_DV and done together for 1 cycle, and return to SLEEP.
REQ-016 rx_DV SHALL be ignored in WAITRESP, SEND, WAITTX, SENDCRC, WAITCRC and END; response_DV SHALL be ignored outside WAITRESP.
REQ-017 Byte counters SHALL be sized clog2 of the largest count plus 1 and SHALL NOT wrap within a transaction; all counters clear on entry to SLEEP.
REQ-018 uart_done arriving in the same cycle as tx_DV SHALL be ignored (counted only in WAITTX).

Reset
REQ-019 Asserting reset low SHALL, asynchronously:
- set the FSM to SLEEP;
- clear all counters and internal buffers;
- drive challenge, tx_byte, mem_data = 0;
- drive start, tx_DV, done, err, busy, led, mem_DV = 0.
REQ-020 Reset asserted mid-transaction SHALL abandon it with no done, err or mem_DV pulse; the first rx_DV after deassertion starts a fresh transaction.

Configuration
REQ-021 Macro PUF_UART_CRC8_EN:
- Defined: after the last response byte, SENDCRC SHALL transmit one CRC-8 byte (poly 0x07, init 0x00, no reflection, no final XOR) computed over all transmitted challenge and response bytes in order, and WAITCRC SHALL wait for uart_done before END.
- Undefined: no CRC logic is present and WAITTX goes directly to END.

Verification
REQ-022 CHAL_BYTES=1, RESP_BYTES=2: rx 0xA5, response 0x1234 -> start 1 cycle after rx_DV; tx_byte sequence A5,12,34; done pulse after the third uart_done.
REQ-023 CHAL_BYTES=2: rx 0x12 then 0x34 -> challenge=0x1234 and start pulse together, one cycle after the second rx_DV; extra rx_DV during WAITTX is ignored.
REQ-024 TIMEOUT=10, no response_DV -> err pulse exactly 10 cycles after entering WAITRESP, busy=0 next cycle, no tx_DV.
REQ-025 mem_we=1, MEM_BYTES=3: rx 01,02,03 -> mem_data=0x010203, mem_DV=done=1 for 1 cycle, led=1 during reception.
REQ-026 PUF_UART_CRC8_EN, CHAL_BYTES=1, RESP_BYTES=8: challenge 0x31, response 0x3233343536373839 -> final tx_byte 0xF4.
REQ-027 Reset low during the fifth response byte -> all outputs 0 immediately, no done; a new transaction then completes normally.
